// File: rtl/global_types.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct
// values, ALU control codes and datapath selector values.
package global_types;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   // Operation class handed to the ALU decoder; FUNCT defers to the funct field.
   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'd0,
      ALU_OP_SUB   = 2'd1,
      ALU_OP_FUNCT = 2'd2
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUREG = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic       ALUA_PC   = 1'b0;
   localparam logic       ALUA_REGA = 1'b1;

   localparam logic [1:0] ALUB_REGB   = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMMSH2 = 2'b11;

   localparam logic [1:0] RES_ALUREG = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;

   localparam logic [1:0] WA_RT = 2'b00;
   localparam logic [1:0] WA_RD = 2'b01;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from operation class and funct field;
// shared with the single-cycle control unit.
module alu_decoder
   import global_types::*;
(
   input  alu_op_t    alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         ALU_OP_SUB:   alu_ctrl = ALU_SUB;
         ALU_OP_FUNCT: begin
            // Unrecognised funct codes fall back to ADD without flagging.
            case (funct)
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default:      alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle MIPS datapath with a shared memory port.
// Outputs are Moore from state; ir_we/pc_en are qualified by mem_ready and zero.
module multicycle_controller
   import global_types::*;
#(
   parameter int ALU_CTRL_W = 4,
   parameter int STATE_W    = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  sel_iord,
   output logic                  ir_we,
   output logic                  pc_en,
   output logic [1:0]            sel_pc,
   output logic                  sel_alu_a,
   output logic [1:0]            sel_alu_b,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  rf_we,
   output logic [1:0]            sel_wa,
   output logic [1:0]            sel_result,
   output logic                  illegal_op,
   output logic [STATE_W-1:0]    state
);

   state_t     cur_state;
   alu_op_t    alu_op;
   logic [3:0] alu_ctrl_dec;
   logic       opcode_ok;

   assign opcode_ok = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_state <= S_FETCH;
      end else begin
         case (cur_state)
            S_FETCH:  if (mem_ready) cur_state <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: cur_state <= S_MEMADR;
                  OP_RTYPE:     cur_state <= S_EXEC;
                  OP_BEQ:       cur_state <= S_BRANCH;
                  OP_ADDI:      cur_state <= S_ADDIEX;
                  OP_J:         cur_state <= S_JUMP;
                  default:      cur_state <= S_FETCH;
               endcase
            end
            S_MEMADR: cur_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) cur_state <= S_MEMWB;
            S_MEMWR:  if (mem_ready) cur_state <= S_FETCH;
            S_EXEC:   cur_state <= S_ALUWB;
            S_ADDIEX: cur_state <= S_ADDIWB;
            default:  cur_state <= S_FETCH;
         endcase
      end
   end

   // While reset is high the block looks like an idle FETCH: selects as in
   // FETCH, every enable low, regardless of the state still held.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      sel_iord   = 1'b0;
      ir_we      = 1'b0;
      pc_en      = 1'b0;
      sel_pc     = PC_ALU;
      sel_alu_a  = ALUA_PC;
      sel_alu_b  = ALUB_REGB;
      alu_op     = ALU_OP_ADD;
      rf_we      = 1'b0;
      sel_wa     = WA_RT;
      sel_result = RES_ALUREG;
      illegal_op = 1'b0;
      if (reset) begin
         sel_alu_b = ALUB_FOUR;
      end else begin
         case (cur_state)
            S_FETCH: begin
               mem_req   = 1'b1;
               sel_alu_b = ALUB_FOUR;
               ir_we     = mem_ready;
               pc_en     = mem_ready;
            end
            S_DECODE: begin
               sel_alu_b  = ALUB_IMMSH2;
               illegal_op = !opcode_ok;
            end
            S_MEMADR: begin
               sel_alu_a = ALUA_REGA;
               sel_alu_b = ALUB_IMM;
            end
            S_MEMRD: begin
               mem_req  = 1'b1;
               sel_iord = 1'b1;
            end
            S_MEMWB: begin
               rf_we      = 1'b1;
               sel_wa     = WA_RT;
               sel_result = RES_MEM;
            end
            S_MEMWR: begin
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               sel_iord = 1'b1;
            end
            S_EXEC: begin
               sel_alu_a = ALUA_REGA;
               alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
               rf_we  = 1'b1;
               sel_wa = WA_RD;
            end
            S_BRANCH: begin
               sel_alu_a = ALUA_REGA;
               alu_op    = ALU_OP_SUB;
               sel_pc    = PC_ALUREG;
               pc_en     = zero;
            end
            S_ADDIEX: begin
               sel_alu_a = ALUA_REGA;
               sel_alu_b = ALUB_IMM;
            end
            S_ADDIWB: rf_we = 1'b1;
            S_JUMP: begin
               sel_pc = PC_JUMP;
               pc_en  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   alu_decoder u_alu_decoder (
      .alu_op   (alu_op),
      .funct    (funct),
      .alu_ctrl (alu_ctrl_dec)
   );

   assign alu_ctrl = ALU_CTRL_W'(alu_ctrl_dec);
   assign state    = STATE_W'(cur_state);

endmodule
